// File: rtl/not_pkg.sv
// Shared definitions for the not_pipe streaming inverter: operation encoding
// and the per-bit result function (bitwise equivalent of the single-bit NOT gates in INV mode).
package not_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_INV  = 2'd0;
  localparam mode_t MODE_PASS = 2'd1;
  localparam mode_t MODE_MASK = 2'd2;

  // Encoding 3 is reserved and falls through to INV.
  function automatic logic not_bit(input logic d, input mode_t mode, input logic m);
    logic r;
    r = ~d;
    case (mode)
      MODE_PASS: r = d;
      MODE_MASK: r = d ^ m;
      default:   r = ~d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/not_stage.sv
// One valid/data pipeline register: loads the upstream word when enabled,
// otherwise holds. Synchronous reset clears both valid and data.
module not_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Loading an empty slot clears valid, but the data register keeps its old value.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = up_valid;
      if (up_valid) d_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid = v_q;
  assign data  = d_q;

endmodule

// File: rtl/not_pipe.sv
// Pipelined INV/PASS/MASK operator with valid/ready backpressure, DEPTH
// register stages with bubble collapsing, and a wrapping output-transfer counter.
module not_pipe
  import not_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  mode_t            in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  logic [WIDTH-1:0] op_data;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    op_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op_data[i] = not_bit(in_data[i], in_mode, in_mask[i]);
    end
  end

  // Stage k can load when out_ready is high or any stage from k downstream is
  // empty; written in closed form so no signal feeds back into itself.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v[j]) rdy[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = op_data;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    not_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[k]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_cnt = cnt_q;

endmodule
